// File: rtl/he_lb_ext_mem_model.sv
// rtl/he_lb_ext_mem_model.sv - on-chip SRAM responder for the HE LB external-memory AXI port
//
// Purpose: accepts AXI4 INCR write and read bursts on independent channels and
// services them from a small word-addressed array, so the HE LB write/read path
// can be exercised without a physical memory controller.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   aw*  (awvalid/awready/awaddr/awid/awlen)          write address channel
//   w*   (wvalid/wready/wdata/wstrb/wlast)            write data channel
//   b*   (bvalid/bready/bid/bresp)                    write response channel
//   ar*  (arvalid/arready/araddr/arid/arlen)          read address channel
//   r*   (rvalid/rready/rdata/rid/rresp/rlast)        read data channel
//   proto_err                           sticky: wlast disagreed with awlen
//   wr_beats, rd_beats                  committed beat counters (wrap mod 2^32)
module he_lb_ext_mem_model #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    proto_err,
    output logic [31:0]             wr_beats,
    output logic [31:0]             rd_beats
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(NB);
    localparam int IDX_W  = ADDR_WIDTH - BSHIFT;
    localparam int DEPTH  = 1 << IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Deliberately not reset: contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Holds the address readies low until the first edge after reset release.
    logic running;

    logic [IDX_W-1:0]    w_idx;
    logic [ID_WIDTH-1:0] w_id;
    logic [7:0]          w_len;
    logic [7:0]          w_cnt;

    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic w_final;

    // Byte-offset bits below the word index are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[BSHIFT-1:0], araddr[BSHIFT-1:0]};

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;
    assign w_final = (w_cnt == w_len);

    assign bid   = w_id;
    assign bresp = 2'b00;
    assign rresp = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            running <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = running;
                if (awvalid && running) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                // Burst length comes from awlen; wlast is only checked.
                if (wvalid && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = running;
                if (arvalid && running) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_beat == r_len);
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx     <= '0;
            w_id      <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            proto_err <= 1'b0;
            wr_beats  <= '0;
        end else begin
            if (aw_hs) begin
                w_idx <= awaddr[ADDR_WIDTH-1:BSHIFT];
                w_id  <= awid;
                w_len <= awlen;
                w_cnt <= '0;
            end else if (w_hs) begin
                w_idx    <= w_idx + IDX_W'(1);
                w_cnt    <= w_cnt + 8'd1;
                wr_beats <= wr_beats + 32'd1;
                if (wlast != w_final) proto_err <= 1'b1;
            end
        end
    end

    // rdata is loaded from the array with non-blocking semantics, so a write
    // committing on the same edge is not seen until a later load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            rid      <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            rd_beats <= '0;
        end else begin
            if (ar_hs) begin
                rdata  <= mem[araddr[ADDR_WIDTH-1:BSHIFT]];
                rid    <= arid;
                r_idx  <= araddr[ADDR_WIDTH-1:BSHIFT];
                r_len  <= arlen;
                r_beat <= '0;
            end else if (r_hs) begin
                rd_beats <= rd_beats + 32'd1;
                if (!rlast) begin
                    r_idx  <= r_idx + IDX_W'(1);
                    rdata  <= mem[r_idx + IDX_W'(1)];
                    r_beat <= r_beat + 8'd1;
                end
            end
        end
    end

endmodule
